// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - ALU control codes, muldiv FSM encoding and default datapath width
package mips_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [1:0] ALUOP_R = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_MUL  = S_MUL,
    ST_DIV  = S_DIV,
    ST_FIX  = S_FIX,
    ST_DONE = S_DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - unsigned shift-add multiply / restoring divide step on operand magnitudes
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo
);

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d, opr_q;
  logic             div_q;
  logic [WIDTH:0]   sum, addend, shifted, diff;

  // Multiply: acc:quo is the running product, quo shifts the multiplier out LSB first.
  // Divide: acc is the partial remainder, quo shifts the dividend out and the quotient in.
  always_comb begin
    acc_d   = acc_q;
    quo_d   = quo_q;
    sum     = acc_q + {1'b0, opr_q};
    addend  = quo_q[0] ? sum : acc_q;
    shifted = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opr_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_d = diff;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted;
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {1'b0, addend[WIDTH:1]};
      quo_d = {addend[0], quo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      quo_q <= '0;
      opr_q <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= '0;
      quo_q <= mode_div ? a_mag : b_mag;
      opr_q <= mode_div ? b_mag : a_mag;
      div_q <= mode_div;
    end else if (en) begin
      acc_q <= acc_d;
      quo_q <= quo_d;
    end
  end

  assign acc = acc_q[WIDTH-1:0];
  assign quo = quo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle mult/div sequencer writing HI/LO and stalling EX
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  md_state_e        state_q;
  logic [CW-1:0]    count_q;
  logic             sa_q, sb_q, div_q, zero_q, done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q, rhi_q, rlo_q;

  logic             op_mul, op_div, op_valid, accept, iter_en;
  logic [WIDTH-1:0] a_mag, b_mag, it_acc, it_quo;
  logic [2*WIDTH-1:0] prod;

  assign op_mul   = (alu_ctrl == {ALUOP_R, ALU_MUL});
  assign op_div   = (alu_ctrl == {ALUOP_R, ALU_DIV});
  assign op_valid = op_mul | op_div;
  assign accept   = (state_q == ST_IDLE) && start && op_valid && !abort;
  assign iter_en  = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign a_mag    = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag    = op_b[WIDTH-1] ? -op_b : op_b;
  assign prod     = {it_acc, it_quo};

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .en       (iter_en),
    .mode_div (op_div),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc      (it_acc),
    .quo      (it_quo)
  );

  // The signed result is staged in rhi/rlo so HI/LO only ever move in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      rhi_q   <= '0;
      rlo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              sa_q    <= op_a[WIDTH-1];
              sb_q    <= op_b[WIDTH-1];
              div_q   <= op_div;
              count_q <= CNT_MAX;
              dbz_q   <= 1'b0;
              zero_q  <= 1'b0;
              if (op_mul) begin
                state_q <= ST_MUL;
              end else if (op_b != '0) begin
                state_q <= ST_DIV;
              end else begin
                rhi_q   <= op_a;
                rlo_q   <= '1;
                zero_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end
          end
          ST_MUL, ST_DIV: begin
            if (count_q == '0) state_q <= ST_FIX;
            else               count_q <= count_q - 1'b1;
          end
          ST_FIX: begin
            if (div_q) begin
              rlo_q <= (sa_q ^ sb_q) ? -it_quo : it_quo;
              rhi_q <= sa_q ? -it_acc : it_acc;
            end else begin
              {rhi_q, rlo_q} <= (sa_q ^ sb_q) ? -prod : prod;
            end
            state_q <= ST_DONE;
          end
          ST_DONE: begin
            hi_q    <= rhi_q;
            lo_q    <= rlo_q;
            dbz_q   <= zero_q;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign stall       = busy | (start & op_valid);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - vector table, random ops against an arithmetic model, corner sequences
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [5:0] C_MUL = 6'b10_0011;
  localparam logic [5:0] C_DIV = 6'b10_0100;
  localparam logic [5:0] C_ADD = 6'b10_0010;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic [5:0]   alu_ctrl;
  logic [W-1:0] op_a, op_b;
  logic         busy, stall, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_hi, prev_lo;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .abort       (abort),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    logic [5:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edbz;
    int           elat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed 64-bit arithmetic; SV / and % truncate toward zero.
  task automatic model(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] ehi, output logic [W-1:0] elo,
                       output logic edbz, output int elat);
    longint la, lb, p;
    la   = longint'($signed(a));
    lb   = longint'($signed(b));
    edbz = 1'b0;
    elat = W + 2;
    if (c == C_MUL) begin
      p = la * lb;
      {ehi, elo} = p;
    end else if (b == '0) begin
      ehi  = a;
      elo  = '1;
      edbz = 1'b1;
      elat = 1;
    end else begin
      ehi = W'(la % lb);
      elo = W'(la / lb);
    end
  endtask

  task automatic wait_done(output int lat, output logic hold_ok);
    hold_ok = 1'b1;
    lat     = 0;
    while (!done && lat < 100) begin
      if (!stall || hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] ghi, output logic [W-1:0] glo,
                        output logic gdbz, output int lat, output logic hold_ok);
    logic req_stall;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    #1 req_stall = stall;
    tick();
    start = 1'b0;
    wait_done(lat, hold_ok);
    hold_ok = hold_ok & req_stall;
    ghi  = hi;
    glo  = lo;
    gdbz = div_by_zero;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ghi, glo, ehi, elo, ra, rb;
    logic         gdbz, edbz, hold_ok;
    int           lat, elat, done_seen;
    logic [5:0]   rc;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    prev_hi = '0; prev_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, stall, done, div_by_zero, hi, lo}, 64'h0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{C_MUL, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[1] = '{C_DIV, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[2] = '{C_DIV, 32'd100,        32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[3] = '{C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[4] = '{C_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34};
    vecs[5] = '{C_DIV, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 34};
    vecs[6] = '{C_DIV, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 34};

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, ghi, glo, gdbz, lat, hold_ok);
      check($sformatf("vec%0d_hi", i), ghi, vecs[i].ehi);
      check($sformatf("vec%0d_lo", i), glo, vecs[i].elo);
      check($sformatf("vec%0d_dbz", i), gdbz, vecs[i].edbz);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].elat);
      check($sformatf("vec%0d_stall_hold", i), hold_ok, 1'b1);
      prev_hi = vecs[i].ehi;
      prev_lo = vecs[i].elo;
    end

    for (int i = 0; i < 24; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? C_MUL : C_DIV;
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = W'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      model(rc, ra, rb, ehi, elo, edbz, elat);
      run_op(rc, ra, rb, ghi, glo, gdbz, lat, hold_ok);
      check($sformatf("rnd%0d_result", i), {ghi, glo}, {ehi, elo});
      check($sformatf("rnd%0d_dbz_lat", i), {gdbz, lat[7:0]}, {edbz, elat[7:0]});
      prev_hi = ehi;
      prev_lo = elo;
    end

    // start during a running mult must not disturb it
    alu_ctrl = C_MUL; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, hold_ok);
    check("ignored_start_latency", lat + 6, 34);
    check("ignored_start_result", {hi, lo}, {32'd0, 32'd6});
    prev_hi = 32'd0; prev_lo = 32'd6;

    run_op(C_MUL, 32'h0001_0000, 32'h0003_0000, ghi, glo, gdbz, lat, hold_ok);
    check("pre_abort_result", {ghi, glo}, {32'd3, 32'd0});
    prev_hi = 32'd3; prev_lo = 32'd0;

    alu_ctrl = C_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_cycle11", busy, 1'b0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);
    check("abort_hilo_kept", {hi, lo}, {32'd3, 32'd0});

    alu_ctrl = C_MUL; op_a = 32'd4; op_b = 32'd4; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 1'b0);

    alu_ctrl = C_ADD; start = 1'b1;
    #1 check("invalid_ctrl_stall", stall, 1'b0);
    tick();
    start = 1'b0;
    check("invalid_ctrl_busy", busy, 1'b0);

    // div by zero, then an in-flight div killed by async reset
    run_op(C_DIV, 32'd100, 32'd0, ghi, glo, gdbz, lat, hold_ok);
    check("dbz_flag_set", gdbz, 1'b1);
    alu_ctrl = C_DIV; op_a = 32'hFFFF_FF9C; op_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("dbz_cleared_on_accept", {busy, div_by_zero}, 2'b10);
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1 check("async_reset_clears", {busy, stall, done, div_by_zero, hi, lo}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    prev_hi = '0; prev_lo = '0;

    run_op(C_MUL, 32'd3, 32'd4, ghi, glo, gdbz, lat, hold_ok);
    check("post_reset_mul", {ghi, glo}, {32'd0, 32'd12});
    check("post_reset_latency", lat, 34);
    prev_hi = 32'd0; prev_lo = 32'd12;

    alu_ctrl = C_MUL; op_a = 32'd6; op_b = 32'hFFFF_FFF9; start = 1'b1;
    tick();
    start = 1'b0;
    check("back_to_back_accept", busy, 1'b1);
    wait_done(lat, hold_ok);
    check("back_to_back_result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFD6});
    check("back_to_back_latency_hold", {hold_ok, lat[7:0]}, {1'b1, 8'd34});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
